// File: rtl/system_bus_arbiter_pkg.sv
// Shared definitions for the CPU/PRC system bus: arbiter states, bus command
// codes and the mux select encoding derived from the arbiter state.
package system_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    CPU_OWN    = 2'd0,
    WAIT_SYNC  = 2'd1,
    PRC_GRANT  = 2'd2,
    TURNAROUND = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IRQ_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_READ  = 2'd3
  } bus_command_t;

  typedef enum logic [1:0] {
    SEL_CPU  = 2'd0,
    SEL_PRC  = 2'd1,
    SEL_HOLD = 2'd2
  } bus_sel_t;

  localparam int WAIT_CNT_W = 8;
  localparam int TA_CNT_W   = 3;

  // Turnaround parks the bus on the held PRC address/data with no strobes.
  function automatic bus_sel_t sel_for_state(input arb_state_t s);
    case (s)
      PRC_GRANT:  sel_for_state = SEL_PRC;
      TURNAROUND: sel_for_state = SEL_HOLD;
      default:    sel_for_state = SEL_CPU;
    endcase
  endfunction

endpackage

// File: rtl/system_bus_arbiter_bus_mux.sv
// Combinational system bus multiplexer; strobes come from at most one
// requester, and the hold path drives an idle command.
module bus_mux
  import system_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 24
) (
  input  bus_sel_t              sel,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [7:0]            cpu_data_out,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [1:0]            cpu_bus_status,
  input  logic [ADDR_WIDTH-1:0] prc_address,
  input  logic [7:0]            prc_data_out,
  input  logic                  prc_read,
  input  logic                  prc_write,
  input  logic [1:0]            prc_bus_status,
  input  logic [ADDR_WIDTH-1:0] hold_address,
  input  logic [7:0]            hold_data,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [7:0]            bus_data,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [1:0]            bus_status
);

  always_comb begin
    bus_address = cpu_address;
    bus_data    = cpu_data_out;
    bus_read    = cpu_read;
    bus_write   = cpu_write;
    bus_status  = cpu_bus_status;
    case (sel)
      SEL_PRC: begin
        bus_address = prc_address;
        bus_data    = prc_data_out;
        bus_read    = prc_read;
        bus_write   = prc_write;
        bus_status  = prc_bus_status;
      end
      SEL_HOLD: begin
        bus_address = hold_address;
        bus_data    = hold_data;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
        bus_status  = IDLE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/system_bus_arbiter.sv
// CPU/PRC system bus arbiter: waits for a CPU instruction boundary (or a
// timeout) before granting the PRC, and inserts idle turnaround on release.
module system_bus_arbiter
  import system_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH        = 24,
  parameter int MAX_WAIT          = 255,
  parameter int TURNAROUND_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [7:0]            cpu_data_out,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [1:0]            cpu_bus_status,
  input  logic                  cpu_sync,
  output logic                  cpu_wait,
  input  logic                  prc_bus_request,
  output logic                  prc_bus_ack,
  input  logic [ADDR_WIDTH-1:0] prc_address,
  input  logic [7:0]            prc_data_out,
  input  logic                  prc_read,
  input  logic                  prc_write,
  input  logic [1:0]            prc_bus_status,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [7:0]            bus_data,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [1:0]            bus_status,
  output logic                  wait_timeout
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);
  localparam logic [TA_CNT_W-1:0]   TA_LAST   = TA_CNT_W'(TURNAROUND_CYCLES - 1);

  arb_state_t              state_reg, state_next;
  logic [WAIT_CNT_W-1:0]   wait_cnt_reg, wait_cnt_next, wait_cnt_inc;
  logic [TA_CNT_W-1:0]     ta_cnt_reg, ta_cnt_next;
  logic                    timeout_next;
  logic                    ack_reg, cpu_wait_reg, timeout_reg;
  logic [ADDR_WIDTH-1:0]   hold_address_reg;
  logic [7:0]              hold_data_reg;
  bus_sel_t                sel;

  assign wait_cnt_inc = wait_cnt_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    ta_cnt_next   = ta_cnt_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      CPU_OWN: begin
        if (prc_bus_request) begin
          wait_cnt_next = '0;
          if (cpu_sync) begin
            state_next = PRC_GRANT;
          end else if (MAX_WAIT == 1) begin
            state_next   = PRC_GRANT;
            timeout_next = 1'b1;
          end else begin
            state_next = WAIT_SYNC;
          end
        end
      end
      WAIT_SYNC: begin
        // A withdrawn request wins over a coincident sync: never grant an idle PRC.
        if (!prc_bus_request) begin
          state_next    = CPU_OWN;
          wait_cnt_next = '0;
        end else if (cpu_sync) begin
          state_next = PRC_GRANT;
        end else begin
          wait_cnt_next = wait_cnt_inc;
          if (wait_cnt_inc == WAIT_LAST) begin
            state_next   = PRC_GRANT;
            timeout_next = 1'b1;
          end
        end
      end
      PRC_GRANT: begin
        if (!prc_bus_request) begin
          state_next  = TURNAROUND;
          ta_cnt_next = '0;
        end
      end
      TURNAROUND: begin
        if (ta_cnt_reg == TA_LAST) begin
          state_next  = CPU_OWN;
          ta_cnt_next = '0;
        end else begin
          ta_cnt_next = ta_cnt_reg + 1'b1;
        end
      end
      default: state_next = CPU_OWN;
    endcase
  end

  // Handshake outputs are registered from the next state so they change on
  // the same edge that moves the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= CPU_OWN;
      wait_cnt_reg     <= '0;
      ta_cnt_reg       <= '0;
      ack_reg          <= 1'b0;
      cpu_wait_reg     <= 1'b0;
      timeout_reg      <= 1'b0;
      hold_address_reg <= '0;
      hold_data_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      ta_cnt_reg   <= ta_cnt_next;
      ack_reg      <= (state_next == PRC_GRANT);
      cpu_wait_reg <= (state_next == PRC_GRANT) || (state_next == TURNAROUND);
      timeout_reg  <= timeout_next;
      if (state_reg == PRC_GRANT) begin
        hold_address_reg <= prc_address;
        hold_data_reg    <= prc_data_out;
      end
    end
  end

  assign sel          = sel_for_state(state_reg);
  assign prc_bus_ack  = ack_reg;
  assign cpu_wait     = cpu_wait_reg;
  assign wait_timeout = timeout_reg;

  bus_mux #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bus_mux (
    .sel            (sel),
    .cpu_address    (cpu_address),
    .cpu_data_out   (cpu_data_out),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_bus_status (cpu_bus_status),
    .prc_address    (prc_address),
    .prc_data_out   (prc_data_out),
    .prc_read       (prc_read),
    .prc_write      (prc_write),
    .prc_bus_status (prc_bus_status),
    .hold_address   (hold_address_reg),
    .hold_data      (hold_data_reg),
    .bus_address    (bus_address),
    .bus_data       (bus_data),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_status     (bus_status)
  );

endmodule
